// File: rtl/sram_controller.sv
// Sequences a 16-bit async SRAM for the data cache: 4-halfword line fills, 2-halfword stores.
// Optional address range checking is enabled by defining SRAM_RANGE_CHECK_EN.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int WW = $clog2(WAIT_CYCLES) + 1;
  localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    phase;
  logic [WW-1:0] wait_cnt;
  logic [17:0]   base_q;
  logic [17:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   off_full;
  logic [18:0]   off;
  logic [17:0]   rd_base;
  logic [17:0]   wr_base;
  logic          bad_addr;
  logic          last_wait;
  logic          last_phase;
  logic          req;

  assign off_full   = address - BASE_ADDR;
  assign off        = off_full[18:0];
  assign rd_base    = {off[18:3], 2'b00};
  assign wr_base    = {off[18:2], 1'b0};
  assign req        = rd_en | wr_en;
  assign last_wait  = (wait_cnt == LAST_WAIT);
  assign last_phase = (state == READ) ? (phase == 2'd3) : (phase == 2'd1);
  assign sram_addr  = addr_q;

`ifdef SRAM_RANGE_CHECK_EN
  logic err_q;
  assign bad_addr = (address < BASE_ADDR) || (off_full[31:19] != 13'd0);
  assign err      = (state == DONE) && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == IDLE)
      err_q <= req && bad_addr;
  end
`else
  // Out-of-range offsets wrap silently into the 18-bit halfword space.
  logic unused_hi;
  assign unused_hi = ^off_full[31:19];
  assign bad_addr  = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = 16'h0000;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_addr)   state_nxt = DONE;
          else if (wr_en) state_nxt = WRITE;
          else            state_nxt = READ;
        end
      end
      READ: begin
        sram_oe_n = 1'b0;
        if (last_wait && last_phase) state_nxt = DONE;
      end
      WRITE: begin
        sram_dq_oe = 1'b1;
        // WE# released on the final wait cycle so address/data are held past the rising edge.
        sram_we_n  = last_wait;
        sram_dq_o  = phase[0] ? wdata_q[31:16] : wdata_q[15:0];
        if (last_wait && last_phase) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 2'd0;
      wait_cnt <= '0;
      base_q   <= 18'd0;
      addr_q   <= 18'd0;
      wdata_q  <= 32'd0;
      rdata    <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          phase    <= 2'd0;
          wait_cnt <= '0;
          if (req && !bad_addr) begin
            base_q  <= wr_en ? wr_base : rd_base;
            addr_q  <= wr_en ? wr_base : rd_base;
            wdata_q <= wdata;
          end
          if (req && bad_addr && !wr_en)
            rdata <= 64'd0;
        end
        READ, WRITE: begin
          if (last_wait) begin
            wait_cnt <= '0;
            phase    <= phase + 2'd1;
            if (state == READ)
              rdata[{phase, 4'b0000} +: 16] <= sram_dq_i;
            if (!last_phase)
              addr_q <= base_q + 18'(phase) + 18'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (WAIT_CYCLES 2 and 4) each with a small SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] rdata;
  logic        ready, err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic [31:0] address4 = 32'd0;
  logic        rd4 = 1'b0;
  logic [63:0] rdata4;
  logic        ready4, err4;
  logic [17:0] sram_addr4;
  logic [15:0] dq_i4, dq_o4;
  logic        dq_oe4, we_n4, oe_n4;

  logic [15:0] mem  [0:63];
  logic [15:0] mem4 [0:63];
  logic        pre_en = 1'b0;
  logic        pre_sel4 = 1'b0;
  logic [5:0]  pre_addr = 6'd0;
  logic [15:0] pre_dat = 16'h0;
  int          we_low_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata), .rd_en(rd_en), .wr_en(wr_en),
    .rdata(rdata), .ready(ready), .err(err), .sram_addr(sram_addr), .sram_dq_i(sram_dq_i),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .address(address4), .wdata(32'd0), .rd_en(rd4), .wr_en(1'b0),
    .rdata(rdata4), .ready(ready4), .err(err4), .sram_addr(sram_addr4), .sram_dq_i(dq_i4),
    .sram_dq_o(dq_o4), .sram_dq_oe(dq_oe4), .sram_we_n(we_n4), .sram_oe_n(oe_n4)
  );

  // SRAM models: asynchronous read, write committed at the end of each WE#-low cycle.
  assign sram_dq_i = mem[sram_addr[5:0]];
  assign dq_i4     = mem4[sram_addr4[5:0]];

  always @(posedge clk) begin
    if (pre_en && !pre_sel4) mem[pre_addr] <= pre_dat;
    if (pre_en && pre_sel4)  mem4[pre_addr] <= pre_dat;
    if (!sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq_o;
      we_low_cnt <= we_low_cnt + 1;
    end
    if (!we_n4) mem4[sram_addr4[5:0]] <= dq_o4;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic sel4, input logic [5:0] a, input logic [15:0] d);
    pre_sel4 = sel4;
    pre_addr = a;
    pre_dat  = d;
    pre_en   = 1'b1;
    step();
    pre_en   = 1'b0;
  endtask

  // Returns the number of cycles from the current (request) cycle to the ready pulse, -1 on timeout.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cyc;
    int we_base;

    step();
    step();
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_we_n", {63'd0, sram_we_n}, 64'd1);
    check("rst_oe_n", {63'd0, sram_oe_n}, 64'd1);
    check("rst_dq_oe", {63'd0, sram_dq_oe}, 64'd0);
    check("rst_addr", {46'd0, sram_addr}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_dq_oe4", {63'd0, dq_oe4}, 64'd0);
    rst = 1'b0;
    step();

    // Word write: halfwords 2 and 3.
    we_base = we_low_cnt;
    address = 32'd1028;
    wdata   = 32'hDEADBEEF;
    wr_en   = 1'b1;
    wait_ready(n);
    check("wr_latency", 64'(n), 64'd5);
    check("wr_err", {63'd0, err}, 64'd0);
    wr_en = 1'b0;
    step();
    check("wr_ready_pulse", {63'd0, ready}, 64'd0);
    check("wr_mem2", {48'd0, mem[2]}, 64'h0000_0000_0000_BEEF);
    check("wr_mem3", {48'd0, mem[3]}, 64'h0000_0000_0000_DEAD);
    check("wr_we_low_cycles", 64'(we_low_cnt - we_base), 64'd2);
    check("wr_rdata_kept", rdata, 64'd0);

    // Line read of halfwords 0..3.
    preload(1'b0, 6'd0, 16'h1111);
    preload(1'b0, 6'd1, 16'h2222);
    preload(1'b0, 6'd2, 16'hBEEF);
    preload(1'b0, 6'd3, 16'hDEAD);
    preload(1'b0, 6'd6, 16'h6666);
    preload(1'b0, 6'd7, 16'h7777);
    address = 32'd1024;
    rd_en   = 1'b1;
    wait_ready(n);
    check("rd_latency", 64'(n), 64'd9);
    check("rd_data", rdata, 64'hDEADBEEF22221111);
    rd_en = 1'b0;
    step();
    step();
    step();
    check("rd_data_held", rdata, 64'hDEADBEEF22221111);
    check("rd_addr_held", {46'd0, sram_addr}, 64'd3);
    check("rd_oe_idle", {63'd0, sram_oe_n}, 64'd1);

    // Simultaneous request: write first, then back-to-back read of the same line.
    address = 32'd1032;
    wdata   = 32'h12345678;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    wait_ready(n);
    check("both_wr_latency", 64'(n), 64'd5);
    check("both_mem4", {48'd0, mem[4]}, 64'h5678);
    check("both_mem5", {48'd0, mem[5]}, 64'h1234);
    check("both_rdata_untouched", rdata, 64'hDEADBEEF22221111);
    wr_en = 1'b0;
    wait_ready(n);
    check("both_rd_latency", 64'(n), 64'd10);
    check("both_rd_data", rdata, 64'h7777666612345678);
    rd_en = 1'b0;
    step();

`ifdef SRAM_RANGE_CHECK_EN
    address = 32'd512;
    rd_en   = 1'b1;
    step();
    check("range_ready", {63'd0, ready}, 64'd1);
    check("range_err", {63'd0, err}, 64'd1);
    check("range_rdata", rdata, 64'd0);
    check("range_oe_n", {63'd0, sram_oe_n}, 64'd1);
    rd_en = 1'b0;
    step();
    check("range_err_clear", {63'd0, err}, 64'd0);
`else
    // 512 - 1024 wraps to halfword 0x3FF00, which aliases halfwords 0..3 of the model.
    address = 32'd512;
    rd_en   = 1'b1;
    wait_ready(n);
    check("wrap_latency", 64'(n), 64'd9);
    check("wrap_err", {63'd0, err}, 64'd0);
    check("wrap_addr", {46'd0, sram_addr}, 64'h3FF03);
    check("wrap_rdata", rdata, 64'hDEADBEEF22221111);
    rd_en = 1'b0;
    step();
`endif

    // Reset in cycle 3 of a read.
    address = 32'd1024;
    rd_en   = 1'b1;
    step();
    step();
    step();
    check("midrd_oe_active", {63'd0, sram_oe_n}, 64'd0);
    rst = 1'b1;
    #1;
    check("midrd_rst_rdata", rdata, 64'd0);
    check("midrd_rst_oe_n", {63'd0, sram_oe_n}, 64'd1);
    rd_en = 1'b0;
    step();
    rst = 1'b0;
    check("midrd_ready", {63'd0, ready}, 64'd0);
    check("midrd_we_n", {63'd0, sram_we_n}, 64'd1);
    check("midrd_oe_n", {63'd0, sram_oe_n}, 64'd1);
    step();
    check("midrd_idle_oe_n", {63'd0, sram_oe_n}, 64'd1);

    // WAIT_CYCLES=4 instance: line at byte 1056 -> halfwords 16..19.
    preload(1'b1, 6'd16, 16'hA0A0);
    preload(1'b1, 6'd17, 16'hB1B1);
    preload(1'b1, 6'd18, 16'hC2C2);
    preload(1'b1, 6'd19, 16'hD3D3);
    address4 = 32'd1056;
    rd4      = 1'b1;
    cyc      = 0;
    for (int k = 0; k < 4; k++) begin
      while (cyc < 1 + 4 * k) begin
        step();
        cyc++;
      end
      check($sformatf("w4_addr_phase%0d", k), {46'd0, sram_addr4}, 64'(16 + k));
    end
    while (cyc < 16) begin
      step();
      cyc++;
    end
    check("w4_not_ready_16", {63'd0, ready4}, 64'd0);
    step();
    check("w4_ready_17", {63'd0, ready4}, 64'd1);
    check("w4_err", {63'd0, err4}, 64'd0);
    check("w4_rdata", rdata4, 64'hD3D3C2C2B1B1A0A0);
    rd4 = 1'b0;
    step();
    check("w4_oe_idle", {63'd0, oe_n4}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
